// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator datapath: opcodes, error codes,
// operand limits and the ALU sequencer state encoding.
package calc_pkg;

  localparam int unsigned W    = 28;
  localparam int          MAXV = 99_999_999;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CHS = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OPND = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StWait,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/calc_range_chk.sv
// Combinational magnitude check of a signed W-bit value against +/-MAXV.
module calc_range_chk
  import calc_pkg::*;
#(
  parameter int unsigned W    = calc_pkg::W,
  parameter int          MAXV = calc_pkg::MAXV
) (
  input  logic [W-1:0] val,
  output logic         in_range
);

  // One extra bit so -MAXV and the most negative input compare without wrap.
  localparam logic signed [W:0] MaxS = (W + 1)'(MAXV);
  localparam logic signed [W:0] MinS = -MaxS;

  logic signed [W:0] val_s;

  always_comb begin
    val_s    = {val[W-1], val};
    in_range = (val_s <= MaxS) && (val_s >= MinS);
  end

endmodule

// File: rtl/calc_alu_sequencer.sv
// Sequences one add/sub/change-sign request through the shared signed adder,
// with operand range checking, response timeout and latched result/status.
module calc_alu_sequencer
  import calc_pkg::*;
#(
  parameter int          MAXV        = calc_pkg::MAXV,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned W           = calc_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res,
  output logic         ovf,
  output logic [1:0]   err,
  output logic [W-1:0] alu_n1,
  output logic [W-1:0] alu_n2,
  output logic         alu_valid_in,
  input  logic         alu_valid_out,
  input  logic         alu_ovf,
  input  logic [W-1:0] alu_d
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    res_q, res_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      err_q, err_d;
  logic [W-1:0]    n1_q, n1_d;
  logic [W-1:0]    n2_q, n2_d;
  logic            vin_q, vin_d;

  logic         a_ok, b_ok;
  logic [W-1:0] neg_a, neg_b;

  calc_range_chk #(
    .W    (W),
    .MAXV (MAXV)
  ) u_chk_a (
    .val      (a_q),
    .in_range (a_ok)
  );

  calc_range_chk #(
    .W    (W),
    .MAXV (MAXV)
  ) u_chk_b (
    .val      (b_q),
    .in_range (b_ok)
  );

  // Operands are range-checked before use, so these negations never overflow.
  assign neg_a = ~a_q + 1'b1;
  assign neg_b = ~b_q + 1'b1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    done_d  = 1'b0;
    vin_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          ovf_d   = 1'b0;
          err_d   = ERR_NONE;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!a_ok || (op_q != OP_CHS && !b_ok) || op_q == OP_RSV) begin
          err_d   = ERR_OPND;
          res_d   = '1;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StErr;
        end else begin
          case (op_q)
            OP_SUB: begin
              n1_d = a_q;
              n2_d = neg_b;
            end
            OP_CHS: begin
              n1_d = '0;
              n2_d = neg_a;
            end
            default: begin
              n1_d = a_q;
              n2_d = b_q;
            end
          endcase
          vin_d   = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A response in the expiry cycle still counts as success.
        if (alu_valid_out) begin
          ovf_d   = alu_ovf;
          res_d   = alu_ovf ? '1 : alu_d;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (cnt_q == TmoLast) begin
          err_d   = ERR_TMO;
          res_d   = '1;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone, StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= ERR_NONE;
      n1_q    <= '0;
      n2_q    <= '0;
      vin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      vin_q   <= vin_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign res          = res_q;
  assign ovf          = ovf_q;
  assign err          = err_q;
  assign alu_n1       = n1_q;
  assign alu_n2       = n2_q;
  assign alu_valid_in = vin_q;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Scoreboard bench for calc_alu_sequencer with a behavioural adder of adjustable
// latency; directed vectors with hand-computed expectations.
module tb_calc_alu_sequencer;
  import calc_pkg::*;

  typedef struct packed {
    logic [27:0] res;
    logic        ovf;
    logic [1:0]  err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [27:0] a;
  logic [27:0] b;
  logic        busy;
  logic        done;
  logic [27:0] res;
  logic        ovf;
  logic [1:0]  err;
  logic [27:0] alu_n1;
  logic [27:0] alu_n2;
  logic        alu_valid_in;
  logic        alu_valid_out;
  logic        alu_ovf;
  logic [27:0] alu_d;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   vin_cnt = 0;
  int   adder_lat = 1;
  bit   adder_en = 1'b1;
  bit   adder_force_ovf = 1'b0;
  logic done_prev = 1'b0;

  calc_alu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .done          (done),
    .res           (res),
    .ovf           (ovf),
    .err           (err),
    .alu_n1        (alu_n1),
    .alu_n2        (alu_n2),
    .alu_valid_in  (alu_valid_in),
    .alu_valid_out (alu_valid_out),
    .alu_ovf       (alu_ovf),
    .alu_d         (alu_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural adder: response valid L edges after the issue edge.
  initial begin : adder_model
    logic [27:0] sum;
    alu_valid_out = 1'b0;
    alu_d         = '0;
    alu_ovf       = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_valid_in && adder_en) begin
        sum = alu_n1 + alu_n2;
        @(posedge clk);
        repeat (adder_lat - 1) @(posedge clk);
        #1;
        alu_valid_out = 1'b1;
        alu_d         = sum;
        alu_ovf       = adder_force_ovf;
        @(posedge clk);
        #1;
        alu_valid_out = 1'b0;
        alu_ovf       = 1'b0;
      end
    end
  end

  always @(negedge clk) if (alu_valid_in) vin_cnt++;

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && done) begin
      if (done_prev) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_width: got done high two cycles expected one");
      end
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending transaction");
      end else begin
        e = sb.pop_front();
        chk("res", {4'h0, res}, {4'h0, e.res});
        chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
        chk("err", {30'h0, err}, {30'h0, e.err});
      end
    end
    done_prev = rst && done;
  end

  task automatic start_op(input logic [1:0] o, input logic [27:0] x, input logic [27:0] y,
                          output int t0);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(input string name, input int t0, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    chk(name, lat, exp_lat);
  endtask

  task automatic push(input logic [27:0] r, input logic o, input logic [1:0] e);
    exp_t x;
    x.res = r;
    x.ovf = o;
    x.err = e;
    sb.push_back(x);
  endtask

  initial begin : stim
    int t0;
    int v0;
    bit done_seen;
    rst   = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_res", {4'h0, res}, 32'h0);
    chk("rst_err", {30'h0, err}, 32'h0);
    chk("rst_n1n2", {4'h0, alu_n1 | alu_n2}, 32'h0);
    chk("rst_vin", {31'h0, alu_valid_in}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ADD, latency 1
    push(28'd99_999_999, 1'b0, ERR_NONE);
    v0 = vin_cnt;
    start_op(OP_ADD, 28'd12_345_678, 28'd87_654_321, t0);
    @(negedge clk);
    chk("add_vin_t2", {31'h0, alu_valid_in}, 32'h1);
    chk("add_n2", {4'h0, alu_n2}, 32'd87_654_321);
    chk("add_busy", {31'h0, busy}, 32'h1);
    wait_done("add_lat", t0, 3);
    chk("add_vin_cnt", vin_cnt - v0, 32'd1);

    // SUB 5-9
    push(28'hFFF_FFFC, 1'b0, ERR_NONE);
    start_op(OP_SUB, 28'd5, 28'd9, t0);
    @(negedge clk);
    chk("sub_n1", {4'h0, alu_n1}, 32'd5);
    chk("sub_n2", {4'h0, alu_n2}, 32'h0FFF_FFF7);
    wait_done("sub_lat", t0, 3);

    // CHS -250, b ignored
    push(28'd250, 1'b0, ERR_NONE);
    start_op(OP_CHS, 28'hFFF_FF06, 28'hFFF_FFFF, t0);
    @(negedge clk);
    chk("chs_n1", {4'h0, alu_n1}, 32'd0);
    chk("chs_n2", {4'h0, alu_n2}, 32'd250);
    wait_done("chs_lat", t0, 3);

    // Adder overflow, latency 3
    adder_lat       = 3;
    adder_force_ovf = 1'b1;
    push(28'hFFF_FFFF, 1'b1, ERR_NONE);
    start_op(OP_ADD, 28'd99_999_999, 28'd1, t0);
    wait_done("ovf_lat", t0, 5);
    @(negedge clk);
    chk("ovf_done_drop", {31'h0, done}, 32'h0);
    chk("ovf_busy_drop", {31'h0, busy}, 32'h0);
    adder_force_ovf = 1'b0;
    adder_lat       = 1;

    // Bad operand a
    push(28'hFFF_FFFF, 1'b0, ERR_OPND);
    v0 = vin_cnt;
    start_op(OP_ADD, 28'd100_000_000, 28'd1, t0);
    wait_done("bada_lat", t0, 1);
    chk("bada_vin_cnt", vin_cnt - v0, 32'd0);

    // Reserved op
    push(28'hFFF_FFFF, 1'b0, ERR_OPND);
    v0 = vin_cnt;
    start_op(OP_RSV, 28'd1, 28'd2, t0);
    wait_done("rsv_lat", t0, 1);
    chk("rsv_vin_cnt", vin_cnt - v0, 32'd0);

    // Timeout, with an ignored start while busy
    adder_en = 1'b0;
    push(28'hFFF_FFFF, 1'b0, ERR_TMO);
    start_op(OP_ADD, 28'd3, 28'd4, t0);
    repeat (5) @(negedge clk);
    op    = OP_SUB;
    a     = 28'd1;
    b     = 28'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("tmo_lat", t0, 18);
    adder_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("tmo_idle", {31'h0, busy}, 32'h0);

    push(28'd15, 1'b0, ERR_NONE);
    start_op(OP_ADD, 28'd7, 28'd8, t0);
    wait_done("after_tmo_lat", t0, 3);

    // Reset during WAIT; late response must be ignored
    adder_lat = 8;
    start_op(OP_ADD, 28'd1, 28'd2, t0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_res", {4'h0, res}, 32'h0);
    chk("arst_n2", {4'h0, alu_n2}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("arst_no_done", {31'h0, done_seen}, 32'h0);
    chk("arst_stay_idle", {31'h0, busy}, 32'h0);
    chk("arst_err", {27'h0, ovf, err, res[1:0]}, 32'h0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

endmodule
